// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package mul_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned ADD_W    = WIDTH + 2;  // room for 3|A| and its partial sums
    localparam int unsigned ITERS_R2 = 32;         // one multiplier bit per CALC cycle
    localparam int unsigned ITERS_R4 = 16;         // two multiplier bits per CALC cycle
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

endpackage

// File: rtl/mul_adder.sv
// Accumulator adder: plain W-bit sum with carry-out. Used for partial-product
// accumulation and, in the radix-4 build, for the 3|A| precompute.
module mul_adder
    import mul_pkg::*;
#(
    parameter int unsigned W = ADD_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/multiplier.sv
// Sequential 32x32 -> 64 multiplier, signed or unsigned operands.
// Magnitudes are multiplied with shift-add and the sign is applied at the end.
// Build option: define MULTIPLIER_RADIX4_EN to retire two multiplier bits per
// cycle (17-cycle latency) instead of one (33-cycle latency). Results match.
module multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = mul_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sign,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 overflow
);

`ifdef MULTIPLIER_RADIX4_EN
    localparam int unsigned ITERS = ITERS_R4;
`else
    localparam int unsigned ITERS = ITERS_R2;
`endif

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mag_a;   // |A|
    logic [WIDTH-1:0]     hi;      // upper half of the running product
    logic [WIDTH-1:0]     lo;      // multiplier bits not yet consumed / product low half
    logic                 neg;
    logic                 sign_q;
`ifdef MULTIPLIER_RADIX4_EN
    logic [WIDTH+1:0]     a3;      // 3|A|, captured at start acceptance
`endif

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH+1:0]     add_x;
    logic [WIDTH+1:0]     add_y;
    logic [WIDTH+1:0]     add_sum;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   res;
    logic                 ovf;
    logic                 unused_bits;

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
    assign abs_a = (sign && a[WIDTH-1]) ? -a : a;
    assign abs_b = (sign && b[WIDTH-1]) ? -b : b;

    // Adder operand select: partial-product add in CALC, 3|A| precompute in IDLE.
    always_comb begin
        add_x = {2'b00, hi};
        add_y = '0;
`ifdef MULTIPLIER_RADIX4_EN
        if (state == IDLE) begin
            add_x = {2'b00, abs_a};
            add_y = {1'b0, abs_a, 1'b0};
        end else begin
            case (lo[1:0])
                2'b00:   add_y = '0;
                2'b01:   add_y = {2'b00, mag_a};
                2'b10:   add_y = {1'b0, mag_a, 1'b0};
                default: add_y = a3;
            endcase
        end
`else
        if (lo[0]) begin
            add_y = {2'b00, mag_a};
        end
`endif
    end

    mul_adder #(
        .W (WIDTH + 2)
    ) u_adder (
        .x    (add_x),
        .y    (add_y),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sums never exceed 34 bits, so the carry-out is structurally zero here.
    assign unused_bits = ^{add_cout, add_sum[WIDTH+1]};

    // Final sign fix-up and overflow detection on the finished magnitude product.
    always_comb begin
        acc = {hi, lo};
        res = neg ? -acc : acc;
        if (sign_q) begin
            ovf = (res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}});
        end else begin
            ovf = (res[2*WIDTH-1:WIDTH] != '0);
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mag_a    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg      <= 1'b0;
            sign_q   <= 1'b0;
`ifdef MULTIPLIER_RADIX4_EN
            a3       <= '0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            prod     <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a  <= abs_a;
                        lo     <= abs_b;
                        hi     <= '0;
                        neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_q <= sign;
                        cnt    <= CNT_W'(ITERS - 1);
`ifdef MULTIPLIER_RADIX4_EN
                        a3     <= add_sum;
`endif
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
`ifdef MULTIPLIER_RADIX4_EN
                    hi <= add_sum[WIDTH+1:2];
                    lo <= {add_sum[1:0], lo[WIDTH-1:2]};
`else
                    hi <= add_sum[WIDTH:1];
                    lo <= {add_sum[0], lo[WIDTH-1:1]};
`endif
                    if (cnt == '0) begin
                        state <= SIGN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SIGN: begin
                    prod     <= res;
                    overflow <= ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed testbench for the sequential multiplier.
module tb_multiplier;

`ifdef MULTIPLIER_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        busy;
    logic        done;
    logic [63:0] prod;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    multiplier #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .sign     (sign),
        .busy     (busy),
        .done     (done),
        .prod     (prod),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands and pulse start for the acceptance edge; returns #1 after it.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                            input bit wait_neg);
        if (wait_neg) @(negedge clk);
        a     = ta;
        b     = tb_v;
        sign  = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done; inject_at>0 pulses a stray start on that cycle.
    task automatic wait_done(input int inject_at, output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == inject_at) begin
                a     = 32'hFFFF_FFFF;
                b     = 32'h0000_0002;
                sign  = 1'b0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [63:0] ep, input logic eo);
        int lat;
        start_op(ta, tb_v, ts, 1'b1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        wait_done(0, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk({tag, "_prod"}, prod, ep);
        chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
    endtask

    initial begin
        int lat;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sign  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_prod", prod, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);

        // Start on the very first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        start_op(32'd6, 32'd7, 1'b1, 1'b0);
        wait_done(0, lat);
        chk("first_lat", 64'(lat), 64'(LAT));
        chk("first_prod", prod, 64'd42);

        // Back-to-back sequence of directed vectors.
        run_op("uns_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        run_op("sgn_m1m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
        run_op("sgn_minsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        run_op("sgn_min1",  32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op("sgn_m2x3",  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        run_op("sgn_m3x5",  32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("sgn_maxsq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 1'b1);
        run_op("uns_x10",   32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, 1'b1);
        run_op("uns_x2",    32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE, 1'b1);
        run_op("uns_small", 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001, 1'b0);
        run_op("sgn_3f3f",  32'h0000_003F, 32'h0000_003F, 1'b1, 64'h0000_0000_0000_0F81, 1'b0);

        // Sampled sweep of small non-negative signed operands.
        for (int i = 0; i < 64; i += 9) begin
            for (int j = 0; j < 64; j += 7) begin
                run_op("small", 32'(i), 32'(j), 1'b1, 64'(i * j), 1'b0);
            end
        end

        // Stray start mid-CALC must be ignored.
        start_op(32'h0000_003F, 32'h0000_003F, 1'b1, 1'b1);
        wait_done(10, lat);
        chk("ign_lat", 64'(lat), 64'(LAT));
        chk("ign_prod", prod, 64'h0000_0000_0000_0F81);
        chk("ign_ovf", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1;
        chk("ign_pulse", {63'd0, done}, 64'd0);
        chk("ign_idle", {63'd0, busy}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("ign_hold", prod, 64'h0000_0000_0000_0F81);

        // Reset in the middle of CALC, then restart right after release.
        run_op("pre_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        start_op(32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_prod", prod, 64'd0);
        chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 1'b0);
        wait_done(0, lat);
        chk("post_rst_lat", 64'(lat), 64'(LAT));
        chk("post_rst_prod", prod, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("post_rst_ovf", {63'd0, overflow}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
